fb_funnel_shifter: RTL and testbench

//  Registered 8-bit funnel shifter for the datapath ALU shift slice. Supports

---
 rtl/fb_funnel_shifter.sv | 72 +++++++
 tb/tb_fb_funnel_shifter.sv | 118 +++++++++++
 2 files changed

// File: rtl/fb_funnel_shifter.sv
// fb_funnel_shifter: registered funnel shifter (SLL/SRL/SLA/SRA/ROL/ROR/pass).
// Defining FB_STATUS_EN adds registered zero (zf) and carry-out (cf) flags.
module fb_funnel_shifter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   input  logic [2:0]       kind_shift,
   input  logic [CNT_W-1:0] s_count,
`ifdef FB_STATUS_EN
   output logic             zf,
   output logic             cf,
`endif
   output logic [WIDTH-1:0] o
);
   localparam logic [CNT_W-1:0] W_C = CNT_W'(WIDTH);
   logic [WIDTH-1:0] hi, lo, o_d, o_q;
   logic [CNT_W-1:0] k, n_sat;
   logic n_big;
   always_comb begin
      n_big = s_count > W_C;
      n_sat = n_big ? W_C : s_count;
      hi = '0;
      lo = i;
      k = '0;
      case (kind_shift)
         // left shifts read the window out of {i,0}, so saturation lands on the all-zero half
         3'b000, 3'b010: begin hi = i; lo = '0; k = W_C - n_sat; end
         3'b001: k = n_sat;
         3'b011: begin hi = {WIDTH{i[WIDTH-1]}}; k = n_sat; end
         3'b100: begin hi = i; k = W_C - (s_count % W_C); end
         3'b101: begin hi = i; k = s_count % W_C; end
         default: ;
      endcase
   end
`ifdef FB_STATUS_EN
   logic [WIDTH+1:0] sh;
   logic cf_d, cf_q, zf_q;
   always_comb begin
      // one guard bit on each side of the window captures the last bit shifted out
      sh = (WIDTH+2)'({hi, lo, 1'b0} >> k);
      o_d = sh[WIDTH:1];
      cf_d = 1'b0;
      case (kind_shift)
         3'b000, 3'b010: cf_d = n_big ? 1'b0 : sh[WIDTH+1];
         3'b001: cf_d = n_big ? 1'b0 : sh[0];
         3'b011: cf_d = sh[0];
         3'b100: cf_d = (s_count == '0) ? 1'b0 : o_d[0];
         3'b101: cf_d = (s_count == '0) ? 1'b0 : o_d[WIDTH-1];
         default: ;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cf_q <= 1'b0;
         zf_q <= 1'b0;
      end else begin
         cf_q <= cf_d;
         zf_q <= ~|o_d;
      end
   assign cf = cf_q;
   assign zf = zf_q;
`else
   assign o_d = WIDTH'({hi, lo} >> k);
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) o_q <= '0;
      else o_q <= o_d;
   assign o = o_q;
endmodule

// File: tb/tb_fb_funnel_shifter.sv
// tb_fb_funnel_shifter: directed vectors with hand-computed results for fb_funnel_shifter.
module tb_fb_funnel_shifter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] din = '0;
   logic [2:0] op = '0;
   logic [3:0] cnt = '0;
   logic [7:0] o;
   logic [7:0] prev = '0;
   int n_cmp = 0;
   int n_bad = 0;
`ifdef FB_STATUS_EN
   logic zf, cf;
`endif

   fb_funnel_shifter #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .i(din),
      .kind_shift(op),
      .s_count(cnt),
`ifdef FB_STATUS_EN
      .zf(zf),
      .cf(cf),
`endif
      .o(o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] a, input logic [2:0] k, input logic [3:0] n, input logic [7:0] exp);
      din = a;
      op = k;
      cnt = n;
      #1 chk("hold", o, prev);
      @(posedge clk);
      #1 chk($sformatf("op%0d i=%h n=%0d", k, a, n), o, exp);
      prev = exp;
   endtask

   initial begin
      #3 chk("reset", o, 8'h00);
      @(posedge clk);
      #1 chk("reset_edge", o, 8'h00);
`ifdef FB_STATUS_EN
      chk("reset_cf", {7'd0, cf}, 8'h00);
      chk("reset_zf", {7'd0, zf}, 8'h00);
`endif
      rst = 1'b0;
      step(8'h02, 3'd0, 4'd1, 8'h04);
      step(8'h02, 3'd1, 4'd1, 8'h01);
      step(8'h02, 3'd2, 4'd1, 8'h04);
      step(8'h02, 3'd3, 4'd1, 8'h01);
      step(8'h02, 3'd4, 4'd1, 8'h04);
      step(8'h02, 3'd5, 4'd1, 8'h01);
      step(8'hFE, 3'd0, 4'd1, 8'hFC);
      step(8'hFE, 3'd1, 4'd1, 8'h7F);
      step(8'hFE, 3'd2, 4'd1, 8'hFC);
      step(8'hFE, 3'd3, 4'd1, 8'hFF);
      step(8'hFE, 3'd4, 4'd1, 8'hFD);
      step(8'hFE, 3'd5, 4'd1, 8'h7F);
      step(8'h96, 3'd0, 4'd8, 8'h00);
      step(8'h96, 3'd1, 4'd8, 8'h00);
      step(8'h96, 3'd3, 4'd8, 8'hFF);
      step(8'h96, 3'd4, 4'd8, 8'h96);
      step(8'h96, 3'd5, 4'd8, 8'h96);
      step(8'h96, 3'd3, 4'd15, 8'hFF);
      step(8'h96, 3'd4, 4'd15, 8'h4B);
      step(8'h96, 3'd0, 4'd15, 8'h00);
      step(8'h96, 3'd1, 4'd15, 8'h00);
      step(8'h96, 3'd3, 4'd3, 8'hF2);
      step(8'h96, 3'd5, 4'd3, 8'hD2);
      step(8'h96, 3'd0, 4'd1, 8'h2C);
      step(8'h96, 3'd4, 4'd1, 8'h2D);
      step(8'h5A, 3'd3, 4'd0, 8'h5A);
      step(8'h5A, 3'd4, 4'd0, 8'h5A);
      step(8'h5A, 3'd0, 4'd0, 8'h5A);
      step(8'hA5, 3'd6, 4'd3, 8'hA5);
      step(8'hA5, 3'd7, 4'd9, 8'hA5);
      // asynchronous reset between edges, then release between edges
      #2 rst = 1'b1;
      #1 chk("async_reset", o, 8'h00);
      din = 8'hFE;
      op = 3'd1;
      cnt = 4'd1;
      @(posedge clk);
      #1 chk("reset_held", o, 8'h00);
      rst = 1'b0;
      #2 chk("after_release", o, 8'h00);
      @(posedge clk);
      #1 chk("first_after_reset", o, 8'h7F);
      prev = 8'h7F;
`ifdef FB_STATUS_EN
      step(8'h81, 3'd0, 4'd1, 8'h02);
      chk("cf_sll", {7'd0, cf}, 8'h01);
      chk("zf_sll", {7'd0, zf}, 8'h00);
      step(8'h01, 3'd1, 4'd1, 8'h00);
      chk("cf_srl", {7'd0, cf}, 8'h01);
      chk("zf_srl", {7'd0, zf}, 8'h01);
      step(8'h96, 3'd3, 4'd15, 8'hFF);
      chk("cf_sra_big", {7'd0, cf}, 8'h01);
      step(8'h96, 3'd1, 4'd15, 8'h00);
      chk("cf_srl_big", {7'd0, cf}, 8'h00);
      step(8'hA5, 3'd6, 4'd3, 8'hA5);
      chk("cf_pass", {7'd0, cf}, 8'h00);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
